// File: rtl/w5300_err_monitor.sv
// w5300_err_monitor: W5300 init/bus watchdogs with sticky active-low error flags; optional auto-clear via W5300_ERR_AUTOCLR_EN
module w5300_err_monitor #(
  parameter logic [31:0] INIT_TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] BUS_TIMEOUT = 32'd256,
  parameter int CNT_W = 8
`ifdef W5300_ERR_AUTOCLR_EN
  , parameter logic [31:0] AUTOCLR_CYCLES = 32'd100_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic             init_fail,
  input  logic             bus_req,
  input  logic             bus_ack,
  input  logic             sock_err,
  input  logic             clr_err,
  output logic [2:0]       err_n,
  output logic             init_ok,
  output logic             bus_busy,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {INIT_WAIT, INIT_OK, INIT_FAIL} init_st_t;
  typedef enum logic {BUS_IDLE, BUS_WAIT} bus_st_t;
  init_st_t init_st, init_nxt;
  bus_st_t bus_st, bus_nxt;
  logic [31:0] init_cnt, bus_cnt;
  logic init_ev, bus_ev, auto_clr;
  logic [2:0] ev;
  logic [CNT_W:0] cnt_sum;
  // Detect error events and compute next FSM states; fail beats done, ack beats expiry
  always_comb begin
    init_ev = (init_st == INIT_WAIT && (init_fail || (!init_done && init_cnt == INIT_TIMEOUT - 1)))
              || (init_st == INIT_OK && init_fail);
    init_nxt = init_st == INIT_WAIT ? (init_ev ? INIT_FAIL : init_done ? INIT_OK : INIT_WAIT)
             : (init_st == INIT_FAIL && init_done) ? INIT_OK : init_st;
    bus_ev = bus_st == BUS_WAIT && !bus_ack && bus_cnt == BUS_TIMEOUT - 1;
    bus_nxt = bus_st == BUS_IDLE ? (bus_req ? BUS_WAIT : BUS_IDLE)
            : (bus_ack || bus_ev) ? BUS_IDLE : BUS_WAIT;
    ev = {sock_err, bus_ev, init_ev};
    cnt_sum = {1'b0, err_count} + (CNT_W+1)'(ev[0]) + (CNT_W+1)'(ev[1]) + (CNT_W+1)'(ev[2]);
  end
  // FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_st <= INIT_WAIT;
      bus_st <= BUS_IDLE;
    end else begin
      init_st <= init_nxt;
      bus_st <= bus_nxt;
    end
  end
  // Init watchdog counts only while waiting for init to complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_cnt <= '0;
    else if (init_st == INIT_WAIT) init_cnt <= init_cnt + 1;
  end
  // Bus watchdog restarts on a request accepted in idle, runs while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_cnt <= '0;
    else if (bus_st == BUS_IDLE && bus_req) bus_cnt <= '0;
    else if (bus_st == BUS_WAIT) bus_cnt <= bus_cnt + 1;
  end
`ifdef W5300_ERR_AUTOCLR_EN
  logic [31:0] quiet_cnt;
  assign auto_clr = ~|ev && !clr_err && err_n != 3'b111 && quiet_cnt == AUTOCLR_CYCLES - 1;
  // Quiet timer: runs while any flag is set, restarts on any error or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quiet_cnt <= '0;
    else quiet_cnt <= (|ev || clr_err || auto_clr) ? '0 : err_n != 3'b111 ? quiet_cnt + 1 : quiet_cnt;
  end
`else
  assign auto_clr = 1'b0;
`endif
  // Sticky flags: a new error in the clear cycle still sets its bit; count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_n <= 3'b111;
      err_count <= '0;
    end else begin
      err_n <= ((clr_err || auto_clr) ? 3'b111 : err_n) & ~ev;
      err_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end
  assign init_ok = init_st == INIT_OK;
  assign bus_busy = bus_st == BUS_WAIT;
endmodule

// File: doc/w5300_err_monitor.md
Name: w5300_err_monitor

Overview:
Upstream error-detection stage for the W5300 Ethernet bring-up path. It watches the W5300 controller's init-completion, bus-transaction and socket-error strobes, and detects init and bus timeouts with watchdog counters. It latches each error class into a sticky, active-low flag, and the err_n[2:0] output feeds the LED status stage directly. It also keeps a saturating error-event count for debug readout.

Parameters:
INIT_TIMEOUT, 32'd50_000_000, cycles allowed from reset release to init_done (1 s at 50 MHz XTAL)
BUS_TIMEOUT, 32'd256, cycles allowed from bus_req to bus_ack
CNT_W, 8, width of err_count
AUTOCLR_CYCLES, 32'd100_000_000, quiet cycles before auto-clear (only with optional feature)

Ports:
clk  input  1  system clock, 50 MHz XTAL
rst_n  input  1  asynchronous active-low reset
init_done  input  1  single-cycle pulse: W5300 init sequence completed OK
init_fail  input  1  single-cycle pulse: W5300 init sequence reported failure
bus_req  input  1  single-cycle pulse: W5300 bus transaction started
bus_ack  input  1  single-cycle pulse: W5300 bus transaction completed
sock_err  input  1  single-cycle pulse: socket interrupt reported error (timeout/disconnect)
clr_err  input  1  single-cycle pulse: clear all sticky flags
err_n  output  3  sticky active-low flags: [0] init error, [1] bus timeout, [2] socket error; 1 = OK
init_ok  output  1  high once init has completed without error
bus_busy  output  1  high while a bus transaction is outstanding
err_count  output  CNT_W  saturating count of error events since reset

Behaviour:
- Clock and reset: single clk domain; all flops use async reset on negedge rst_n.
- Reset values: err_n=3'b111, init_ok=0, bus_busy=0, err_count=0, all counters 0, init FSM=INIT_WAIT, bus FSM=BUS_IDLE.
- Init FSM, states INIT_WAIT / INIT_OK / INIT_FAIL:
  - INIT_WAIT: init counter increments every cycle.
  - INIT_WAIT->INIT_OK on init_done; init_ok=1 on the next cycle.
  - INIT_WAIT->INIT_FAIL on init_fail, or when the counter reaches INIT_TIMEOUT-1 without init_done. Either way, err_n[0] clears next cycle.
  - init_done and init_fail in the same cycle: fail wins.
  - INIT_FAIL->INIT_OK on a later init_done. init_ok goes 1, but err_n[0] stays 0 until cleared.
  - INIT_OK is terminal until reset; init_fail in INIT_OK sets err_n[0] and counts an event.
- Bus watchdog FSM, states BUS_IDLE / BUS_WAIT:
  - BUS_IDLE->BUS_WAIT on bus_req; counter loads 0; bus_busy=1 next cycle.
  - BUS_WAIT->BUS_IDLE on bus_ack.
  - BUS_WAIT->BUS_IDLE on timeout, when the counter reaches BUS_TIMEOUT-1; err_n[1]=0 next cycle.
  - bus_ack in the expiry cycle wins: no error.
  - bus_req while in BUS_WAIT is ignored; the watchdog is not restarted.
  - bus_ack while in BUS_IDLE is ignored.
  - bus_req and bus_ack together in BUS_IDLE: enter BUS_WAIT; that ack is ignored.
- Socket error: sock_err drives err_n[2]=0 on the next cycle.
- Flag latency: every flag set is registered, one cycle after the detecting event.
- Clear rules:
  - clr_err sets err_n to 3'b111 next cycle; FSM states are unchanged.
  - A new error on the same cycle as clr_err wins: that bit is set, the other bits clear.
- err_count:
  - Increments by the number of distinct error events in a cycle (0..3). The three events are init fail/timeout, bus timeout and sock_err.
  - Saturates at 2^CNT_W-1.
  - Not affected by clr_err.
  - Events whose flag is already set still count.
- Reset mid-transaction: all state aborts immediately to reset values; no flag is retained.

Optional Feature:
Macro W5300_ERR_AUTOCLR_EN.
- Defined:
  - A quiet counter resets on any error event or clr_err, and otherwise increments while err_n != 3'b111.
  - On reaching AUTOCLR_CYCLES-1, err_n returns to 3'b111 next cycle and the counter returns to 0.
- Undefined: no quiet counter exists; flags clear only via clr_err or reset.

Test Plan (parameters for all: INIT_TIMEOUT=100, BUS_TIMEOUT=8, CNT_W=4, AUTOCLR_CYCLES=50):
1. Reset release, init_done at cycle 10 -> init_ok=1 at cycle 11, err_n stays 3'b111, err_count=0.
2. No init_done for 100 cycles -> err_n=3'b110 at cycle 101, err_count=1. Later init_done -> init_ok=1, err_n still 3'b110. Then clr_err -> err_n=3'b111.
3. bus_req, bus_ack 5 cycles later -> bus_busy high 5 cycles, no error. Next bus_req with no ack -> err_n[1]=0 8 cycles later, bus_busy=0. Ack in the expiry cycle -> no error.
4. sock_err on the same cycle as clr_err, with err_n=3'b100 beforehand -> err_n=3'b011. sock_err on the same cycle as a bus timeout -> err_count increments by 2.
5. Drive 20 sock_err pulses -> err_count saturates at 15. Assert rst_n low during BUS_WAIT -> all outputs at reset values immediately.
6. W5300_ERR_AUTOCLR_EN defined: single sock_err, then quiet -> err_n returns to 3'b111 after 50 cycles. With the macro undefined -> err_n remains 3'b011.
